// File: rtl/ram_port_arb_pkg.sv
// rtl/ram_port_arb_pkg.sv - default parameters and round-robin index helper for ram_port_arb
package ram_port_arb_pkg;

    localparam int DefNrHosts        = 2;
    localparam int DefDataWidth      = 32;
    localparam int DefAddrWidth      = 32;
    localparam int DefMaxOutstanding = 2;

    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/ram_port_arb_if.sv
// rtl/ram_port_arb_if.sv - host-side and device-side bus bundle for ram_port_arb
interface ram_port_arb_if
    import ram_port_arb_pkg::*;
#(
    parameter int NrHosts   = DefNrHosts,
    parameter int DataWidth = DefDataWidth,
    parameter int AddrWidth = DefAddrWidth
);

    logic [NrHosts-1:0]     host_req_i;
    logic [NrHosts-1:0]     host_gnt_o;
    logic [AddrWidth-1:0]   host_addr_i  [NrHosts];
    logic [NrHosts-1:0]     host_we_i;
    logic [DataWidth/8-1:0] host_be_i    [NrHosts];
    logic [DataWidth-1:0]   host_wdata_i [NrHosts];
    logic [NrHosts-1:0]     host_rvalid_o;
    logic [DataWidth-1:0]   host_rdata_o;
    logic                   host_err_o;

    logic                   dev_req_o;
    logic                   dev_gnt_i;
    logic [AddrWidth-1:0]   dev_addr_o;
    logic                   dev_we_o;
    logic [DataWidth/8-1:0] dev_be_o;
    logic [DataWidth-1:0]   dev_wdata_o;
    logic                   dev_rvalid_i;
    logic [DataWidth-1:0]   dev_rdata_i;
    logic                   dev_err_i;

    logic                   unexp_rsp_o;

    // slave: the arbiter's view
    modport slave (
        input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        output dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        input  dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        output unexp_rsp_o
    );

    modport master (
        output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
        input  dev_req_o, dev_addr_o, dev_we_o, dev_be_o, dev_wdata_o,
        output dev_gnt_i, dev_rvalid_i, dev_rdata_i, dev_err_i,
        input  unexp_rsp_o
    );

endinterface

// File: rtl/ram_port_arb_id_fifo.sv
// rtl/ram_port_arb_id_fifo.sv - in-order FIFO of granted host IDs awaiting a response
module ram_port_arb_id_fifo
    import ram_port_arb_pkg::*;
#(
    parameter int Width = 1,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] data,
    output logic             full,
    output logic             empty,
    output logic [Width-1:0] head
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  cnt_q;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= data;
        end
    end

    // Push while full is only issued together with a pop, so the slot being
    // overwritten is the head that leaves this cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign full  = (cnt_q == CntW'(Depth));
    assign empty = (cnt_q == '0);
    assign head  = mem[rd_ptr_q];

endmodule

// File: rtl/ram_port_arb.sv
// rtl/ram_port_arb.sv - round-robin arbiter sharing one single-port memory between several hosts
module ram_port_arb
    import ram_port_arb_pkg::*;
#(
    parameter int NrHosts        = DefNrHosts,
    parameter int DataWidth      = DefDataWidth,
    parameter int AddrWidth      = DefAddrWidth,
    parameter int MaxOutstanding = DefMaxOutstanding
) (
    input  logic         clk_i,
    input  logic         rst_i,
    ram_port_arb_if.slave bus
);

    localparam int IdW = $clog2(NrHosts);

    logic [IdW-1:0]     last_q;
    logic [IdW-1:0]     win;
    logic [IdW-1:0]     cand;
    logic               found;
    logic [IdW-1:0]     head;
    logic               any_req;
    logic               can_issue;
    logic               dev_req;
    logic               handshake;
    logic               pop;
    logic               full;
    logic               empty;
    logic               unexp_q;
    logic [NrHosts-1:0] gnt;
    logic [NrHosts-1:0] rvalid;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        win   = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int k = 1; k <= NrHosts; k++) begin
            cand = IdW'(rr_index(int'(last_q), k, NrHosts));
            if (!found && bus.host_req_i[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign any_req   = |bus.host_req_i;
    assign can_issue = !full || bus.dev_rvalid_i;
    assign dev_req   = any_req && can_issue;
    assign handshake = dev_req && bus.dev_gnt_i;
    assign pop       = bus.dev_rvalid_i && !empty;

    always_comb begin
        gnt    = '0;
        rvalid = '0;
        if (handshake) begin
            gnt[win] = 1'b1;
        end
        if (pop) begin
            rvalid[head] = 1'b1;
        end
    end

    assign bus.dev_req_o     = dev_req;
    assign bus.dev_addr_o    = bus.host_addr_i[win];
    assign bus.dev_we_o      = bus.host_we_i[win];
    assign bus.dev_be_o      = bus.host_be_i[win];
    assign bus.dev_wdata_o   = bus.host_wdata_i[win];
    assign bus.host_gnt_o    = gnt;
    assign bus.host_rvalid_o = rvalid;
    assign bus.host_rdata_o  = bus.dev_rdata_i;
    assign bus.host_err_o    = bus.dev_err_i;
    assign bus.unexp_rsp_o   = unexp_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q  <= IdW'(NrHosts - 1);
            unexp_q <= 1'b0;
        end else begin
            if (handshake) begin
                last_q <= win;
            end
            if (bus.dev_rvalid_i && empty) begin
                unexp_q <= 1'b1;
            end
        end
    end

    ram_port_arb_id_fifo #(
        .Width (IdW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (handshake),
        .pop   (pop),
        .data  (win),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

endmodule
